// File: rtl/pe_arr_feeder.sv
// pe_arr_feeder: skews activation/weight beats onto the edges of a PE array.
// Optional beat counter is built only when PE_ARR_FEEDER_PERF_CNT_EN is defined.
module pe_arr_feeder_lane #(
   parameter int K = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_vld,
   input  logic [7:0] i_dat,
   output logic       o_vld,
   output logic [7:0] o_dat
);
   logic [K:0][7:0] r_d;
   logic [K:0]      r_v;
   logic [K:0][7:0] w_d_nxt;
   logic [K:0]      w_v_nxt;
   logic [7:0]      w_in;

   assign w_in = i_vld ? i_dat : 8'h00;

   if (K == 0) begin : g_s0
      assign w_d_nxt = w_in;
      assign w_v_nxt = i_vld;
   end else begin : g_sn
      assign w_d_nxt = {r_d[K-1:0], w_in};
      assign w_v_nxt = {r_v[K-1:0], i_vld};
   end

   // K+1 stage delay line; bubbles travel as zero data with valid low
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_d <= '0;
         r_v <= '0;
      end else begin
         r_d <= w_d_nxt;
         r_v <= w_v_nxt;
      end
   end

   assign o_dat = r_d[K];
   assign o_vld = r_v[K];
endmodule

module pe_arr_feeder #(
   parameter int ROWS = 8,
   parameter int COLS = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_last,
   input  logic [ROWS*8-1:0]    s_a,
   input  logic [COLS*8-1:0]    s_w,
   output logic [ROWS-1:0][7:0] in_a,
   output logic [COLS-1:0][7:0] in_w,
   output logic                 fire,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          beat_cnt
);
   localparam int D  = (ROWS > COLS) ? ROWS : COLS;
   localparam int CW = $clog2(D + 1);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_rdy;
   logic            r_done;
   logic            w_done_nxt;
   logic            w_beat;
   logic [ROWS-1:0] w_va;
   logic [COLS-1:0] w_vw;

   assign w_beat  = s_valid & r_rdy;
   assign s_ready = r_rdy;
   assign done    = r_done;
   assign busy    = (r_state != IDLE);
   assign fire    = (|w_va) | (|w_vw);

   // burst sequencing; flush counter expires as the last lane drains
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_beat) begin
               w_state_nxt = s_last ? FLUSH : STREAM;
               w_cnt_nxt   = CW'(D);
            end
         end
         STREAM: begin
            if (w_beat && s_last) begin
               w_state_nxt = FLUSH;
               w_cnt_nxt   = CW'(D);
            end
         end
         FLUSH: begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // state, flush counter, registered ready and done pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rdy   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rdy   <= (w_state_nxt != FLUSH);
         r_done  <= w_done_nxt;
      end
   end

`ifdef PE_ARR_FEEDER_PERF_CNT_EN
   logic [15:0] r_beat_cnt;

   // beats of the current burst; restarts on the first beat taken in IDLE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_beat_cnt <= '0;
      end else if (w_beat) begin
         if (r_state == IDLE) begin
            r_beat_cnt <= 16'd1;
         end else if (r_beat_cnt != 16'hFFFF) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
         end
      end
   end

   assign beat_cnt = r_beat_cnt;
`else
   assign beat_cnt = '0;
`endif

   for (genvar k = 0; k < ROWS; k++) begin : g_a
      pe_arr_feeder_lane #(.K(k)) u_lane (
         .clk   (clk),
         .rstn  (rstn),
         .i_vld (w_beat),
         .i_dat (s_a[8*k +: 8]),
         .o_vld (w_va[k]),
         .o_dat (in_a[k])
      );
   end

   for (genvar k = 0; k < COLS; k++) begin : g_w
      pe_arr_feeder_lane #(.K(k)) u_lane (
         .clk   (clk),
         .rstn  (rstn),
         .i_vld (w_beat),
         .i_dat (s_w[8*k +: 8]),
         .o_vld (w_vw[k]),
         .o_dat (in_w[k])
      );
   end
endmodule

// File: doc/pe_arr_feeder.md
PE_ARR_FEEDER -- requirements
Module: pe_arr_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 8: activation lanes, equal to the array row count.
REQ-002 SHALL have parameter COLS, default 8: weight lanes, equal to the array column count.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port s_valid, input, 1: upstream beat valid.
REQ-006 SHALL have port s_ready, output, 1: feeder can accept a beat.
REQ-007 SHALL have port s_last, input, 1: final beat of a burst; sampled with s_valid.
REQ-008 SHALL have port s_a, input, ROWS*8: packed activations; lane r is bits [8r+7:8r].
REQ-009 SHALL have port s_w, input, COLS*8: packed weights; lane c is bits [8c+7:8c].
REQ-010 SHALL have port in_a, output, 8 x ROWS array: skewed activations to the array.
REQ-011 SHALL have port in_w, output, 8 x COLS array: skewed weights to the array.
REQ-012 SHALL have port fire, output, 1: array enable; high while any skewed lane carries valid data.
REQ-013 SHALL have port busy, output, 1: high in STREAM or FLUSH.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when the burst is fully flushed.
REQ-015 SHALL have port beat_cnt, output, 16: accepted beats in the current or last burst.

Function
REQ-016 SHALL define a handshake beat as a cycle with s_valid=1 and s_ready=1.
REQ-017 SHALL register lane k of a beat onto in_a[k] / in_w[k] exactly k+1 cycles after the beat (lane 0 latency 1, lane k latency k+1).
REQ-018 SHALL drive 0 on each lane position that holds no accepted beat (bubble) and SHALL keep a per-stage valid bit alongside the data.
REQ-019 SHALL drive fire=1 in any cycle where at least one in_a or in_w lane carries valid data, else 0.
REQ-020 SHALL have a state machine with states IDLE, STREAM and FLUSH.
REQ-021 SHALL drive s_ready=1 in IDLE and STREAM and s_ready=0 in FLUSH.
REQ-022 IDLE: a beat with s_last=0 SHALL move to STREAM; a beat with s_last=1 SHALL move directly to FLUSH.
REQ-023 STREAM: a beat with s_last=1 SHALL move to FLUSH; s_valid=0 SHALL remain in STREAM and insert a bubble.
REQ-024 On entry to FLUSH, SHALL load a flush counter with D = max(ROWS,COLS); it decrements once per cycle.
REQ-025 When the counter reaches 0, SHALL pulse done for one cycle and move to IDLE.
REQ-026 done timing: done SHALL be asserted in the cycle after the last valid lane of the final beat leaves the outputs; fire=0 by that cycle.
REQ-027 Ignored inputs: s_valid during FLUSH SHALL be ignored and beats SHALL NOT be lost (upstream holds, per handshake).
REQ-028 beat_cnt: SHALL clear on the first beat of a burst accepted in IDLE.
REQ-029 beat_cnt: SHALL increment on each beat, saturate at 16'hFFFF, and hold after done.
REQ-030 Data: SHALL pass through unmodified, without arithmetic.

Reset
REQ-031 Asserting rstn=0 SHALL immediately force IDLE, all skew data and valid bits to 0, and in_a=in_w=0, fire=0, busy=0, done=0, beat_cnt=0, s_ready=0.
REQ-032 s_ready SHALL rise the first cycle after rstn deasserts.
REQ-033 Reset mid-burst SHALL discard all in-flight beats without producing a done pulse.

Configuration
REQ-034 Macro PE_ARR_FEEDER_PERF_CNT_EN: when defined, beat_cnt SHALL behave per REQ-028/029.
REQ-035 Macro PE_ARR_FEEDER_PERF_CNT_EN: when undefined, beat_cnt SHALL be constant 0, no counter register SHALL exist, and all other behaviour SHALL be identical.

Verification (ROWS=COLS=4)
REQ-036 Single beat, s_a=32'h04030201, s_w=32'h08070605, s_last=1 in IDLE -> in_a[0]=1 at +1, in_a[3]=4 at +4, other cycles 0; fire high +1..+4; done at +5; beat_cnt=1.
REQ-037 Burst of 3 back-to-back beats, last on third -> fire high 6 consecutive cycles; s_ready=0 for 4 cycles after third beat; single done pulse.
REQ-038 Burst with s_valid=0 gap between beats 1 and 2 -> zeros with valid=0 on each lane at gap position; fire stays high while an earlier or later lane is valid.
REQ-039 s_valid held high during FLUSH with new data -> no acceptance until IDLE; then accepted beat appears first on in_a[0] one cycle after acceptance.
REQ-040 rstn pulsed low mid-STREAM after 2 beats -> all outputs 0 immediately, no done, beat_cnt=0; next burst behaves as REQ-036.
REQ-041 Build without PE_ARR_FEEDER_PERF_CNT_EN, rerun REQ-037 -> beat_cnt=0 throughout; all other outputs unchanged.
